// File: rtl/ann_pkg.sv
// ann_pkg: shared types, widths and requantizer for the digit-recognition ANN datapath
package ann_pkg;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    localparam int ACC_W = 32;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, OUT} state_t;
    function automatic logic signed [DATA_W-1:0] requant(input logic signed [63:0] a, input int shift, input logic relu);
        logic signed [63:0] v;
        v = a >>> shift;
        v = (relu && v < 0) ? 64'sd0 : v;
        return v > 64'sd127 ? 8'h7f : v < -64'sd128 ? 8'h80 : v[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/mult.sv
// Mult: combinational signed 8x8 multiplier (x, w in; 16-bit signed product o out)
module Mult import ann_pkg::*; (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [PROD_W-1:0] o
);
    assign o = x * w;
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequences one neuron's MAC over X/W memories, adds bias, requantizes and applies ReLU
//   clk, rst_n (async active-low); start/bias from layer controller; rd_en/rd_addr to X/W memories;
//   x_data/w_data back one cycle after rd_en; busy, done pulse and held signed 8-bit result out.
module neuron_mac_seq import ann_pkg::*; #(
    parameter int N_INPUTS = 784,
    parameter int ADDR_W = 10,
    parameter int ACC_W = ann_pkg::ACC_W,
    parameter int SHIFT = 7,
    parameter int RELU = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);
    state_t state, nxt;
    logic [ADDR_W-1:0] cnt;
    logic signed [ACC_W-1:0] acc, bias_r, acc_b;
    logic signed [PROD_W-1:0] prod;
    logic pair_v;
    Mult u_mult (.x(x_data), .w(w_data), .o(prod));
    // counter stops on the last address so rd_addr holds it after the sweep
    assign rd_addr = cnt;
    assign acc_b = acc + bias_r;
    always_comb begin
        nxt = state;
        rd_en = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        nxt = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN ? (cnt == LAST ? DRAIN : RUN) :
              state == DRAIN ? BIAS :
              state == BIAS ? OUT : IDLE;
        rd_en = state == RUN;
        busy = state != IDLE;
        done = state == OUT;
    end
    // pair_v marks the cycle where memory data answers last cycle's read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            bias_r <= '0;
            pair_v <= 1'b0;
            result <= '0;
        end else begin
            state <= nxt;
            pair_v <= rd_en;
            if (state == IDLE && start) begin
                acc <= '0;
                bias_r <= bias;
                cnt <= '0;
            end
            if (state == RUN && cnt != LAST) cnt <= cnt + 1'b1;
            if (pair_v) acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            // result is registered here so it is already valid while done is high in OUT
            if (state == BIAS) begin
                acc <= acc_b;
                result <= requant(64'(acc_b), SHIFT, RELU != 0);
            end
        end
    end
endmodule
